// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW operand forwarding from EX/MEM and MEM/WB.
// Supports stall (hold, with retiring writeback refresh) and flush (bubble).
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1_addr,
    input  logic [REGW-1:0] id_rs2_addr,
    input  logic [REGW-1:0] id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [OPW-1:0]  id_instructions,
    input  logic            id_reg_write,
    input  logic            exm_reg_write,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_v1,
    output logic [XLEN-1:0] ex_v2,
    output logic [OPW-1:0]  ex_instructions,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b
);

    logic            valid_q;
    logic            reg_write_q;
    logic            use_imm_q;
    logic [REGW-1:0] rd_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [XLEN-1:0] d1_q;
    logic [XLEN-1:0] d2_q;
    logic [OPW-1:0]  op_q;

    logic exm_hit1, exm_hit2, wb_hit1, wb_hit2;

    assign exm_hit1 = exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_q);
    assign exm_hit2 = exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_q);
    assign wb_hit1  = wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q);
    assign wb_hit2  = wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            use_imm_q   <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            op_q        <= '0;
        end else if (stall) begin
            // Writer may retire while we wait; refresh so the operand stays current.
            if (wb_hit1)
                d1_q <= wb_result;
            if (wb_hit2 && !use_imm_q)
                d2_q <= wb_result;
        end else begin
            valid_q     <= id_valid;
            reg_write_q <= id_reg_write & id_valid;
            use_imm_q   <= id_use_imm;
            rd_q        <= id_rd_addr;
            rs1_q       <= id_rs1_addr;
            rs2_q       <= id_rs2_addr;
            d1_q        <= id_rs1_data;
            d2_q        <= id_use_imm ? id_imm : id_rs2_data;
            op_q        <= id_instructions;
        end
    end

    always_comb begin
        ex_v1    = d1_q;
        ex_fwd_a = 2'd0;
        if (exm_hit1) begin
            ex_v1    = exm_result;
            ex_fwd_a = 2'd1;
        end else if (wb_hit1) begin
            ex_v1    = wb_result;
            ex_fwd_a = 2'd2;
        end
    end

    always_comb begin
        ex_v2    = d2_q;
        ex_fwd_b = 2'd0;
        if (!use_imm_q) begin
            if (exm_hit2) begin
                ex_v2    = exm_result;
                ex_fwd_b = 2'd1;
            end else if (wb_hit2) begin
                ex_v2    = wb_result;
                ex_fwd_b = 2'd2;
            end
        end
    end

    assign ex_valid        = valid_q;
    assign ex_reg_write    = reg_write_q;
    assign ex_rd           = rd_q;
    assign ex_instructions = op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the stage contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid, id_use_imm, id_reg_write;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [9:0]  id_instructions;
    logic        exm_reg_write, wb_reg_write;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_result, wb_result;
    logic        ex_valid, ex_reg_write;
    logic [31:0] ex_v1, ex_v2;
    logic [9:0]  ex_instructions;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_fwd_a, ex_fwd_b;

    int passed = 0;
    int total  = 0;

    // Model of what the stage currently holds.
    logic        m_valid, m_rw, m_imm;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_d1, m_d2;
    logic [9:0]  m_op;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_instructions(id_instructions), .id_reg_write(id_reg_write),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_result(exm_result), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_v1(ex_v1), .ex_v2(ex_v2),
        .ex_instructions(ex_instructions), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b)
    );

    always #5 clk = ~clk;

    function automatic logic exm_m(input logic [4:0] a);
        return exm_reg_write && exm_rd != 0 && exm_rd == a;
    endfunction

    function automatic logic wb_m(input logic [4:0] a);
        return wb_reg_write && wb_rd != 0 && wb_rd == a;
    endfunction

    function automatic logic [31:0] e_v1();
        if (exm_m(m_rs1)) return exm_result;
        if (wb_m(m_rs1)) return wb_result;
        return m_d1;
    endfunction

    function automatic logic [1:0] e_fa();
        if (exm_m(m_rs1)) return 2'd1;
        if (wb_m(m_rs1)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] e_v2();
        if (m_imm) return m_d2;
        if (exm_m(m_rs2)) return exm_result;
        if (wb_m(m_rs2)) return wb_result;
        return m_d2;
    endfunction

    function automatic logic [1:0] e_fb();
        if (m_imm) return 2'd0;
        if (exm_m(m_rs2)) return 2'd1;
        if (wb_m(m_rs2)) return 2'd2;
        return 2'd0;
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst || flush) begin
            {m_valid, m_rw, m_imm, m_rd, m_rs1, m_rs2} = '0;
            {m_d1, m_d2, m_op} = '0;
        end else if (stall) begin
            if (wb_m(m_rs1)) m_d1 = wb_result;
            if (wb_m(m_rs2) && !m_imm) m_d2 = wb_result;
        end else begin
            m_valid = id_valid;
            m_rw    = id_reg_write & id_valid;
            m_imm   = id_use_imm;
            m_rd    = id_rd_addr;
            m_rs1   = id_rs1_addr;
            m_rs2   = id_rs2_addr;
            m_d1    = id_rs1_data;
            m_d2    = id_use_imm ? id_imm : id_rs2_data;
            m_op    = id_instructions;
        end
    endtask

    task automatic quiet_fwd();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic load(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic ui, input logic [9:0] op);
        id_valid = 1; id_reg_write = 1;
        id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_use_imm = ui; id_instructions = op;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0;
        id_valid = 1; id_reg_write = 1; id_use_imm = 0;
        id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3;
        id_rs1_data = 7; id_rs2_data = 8; id_imm = 9;
        id_instructions = 10'h3ff;
        quiet_fwd();
        tick();
        tick();
        rst = 0;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %0d want 0", ex_valid); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL reset_rw got %0d want 0", ex_reg_write); else passed++;
        total++; if (ex_instructions !== 10'h0) $display("FAIL reset_op got %h want 0", ex_instructions); else passed++;
        total++; if (ex_rd !== 5'h0) $display("FAIL reset_rd got %0d want 0", ex_rd); else passed++;
        total++; if (ex_v1 !== 32'h0) $display("FAIL reset_v1 got %h want 0", ex_v1); else passed++;
        total++; if (ex_v2 !== 32'h0) $display("FAIL reset_v2 got %h want 0", ex_v2); else passed++;
        total++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0)
            $display("FAIL reset_fwd got %0d/%0d want 0/0", ex_fwd_a, ex_fwd_b); else passed++;
    endtask

    task automatic test_basic();
        quiet_fwd();
        load(5, 4, 1, 5, 4, 0, 0, 10'h000);
        total++; if (ex_v1 !== 32'd5) $display("FAIL basic_v1 got %h want 5", ex_v1); else passed++;
        total++; if (ex_v2 !== 32'd4) $display("FAIL basic_v2 got %h want 4", ex_v2); else passed++;
        total++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0)
            $display("FAIL basic_fwd got %0d/%0d want 0/0", ex_fwd_a, ex_fwd_b); else passed++;
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_reg_write !== 1'b1)
            $display("FAIL basic_ctrl got v%0d rd%0d rw%0d want 1/1/1", ex_valid, ex_rd, ex_reg_write); else passed++;
    endtask

    task automatic test_forward_priority();
        quiet_fwd();
        load(3, 8, 2, 32'h33, 32'h88, 0, 0, 10'h007);
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAA;
        wb_reg_write = 1; wb_rd = 3; wb_result = 32'hBB;
        #1;
        total++; if (ex_v1 !== 32'hAA || ex_fwd_a !== 2'd1)
            $display("FAIL fwd_exm got %h/%0d want aa/1", ex_v1, ex_fwd_a); else passed++;
        exm_reg_write = 0;
        #1;
        total++; if (ex_v1 !== 32'hBB || ex_fwd_a !== 2'd2)
            $display("FAIL fwd_wb got %h/%0d want bb/2", ex_v1, ex_fwd_a); else passed++;
        wb_rd = 8;
        #1;
        total++; if (ex_v1 !== 32'h33 || ex_v2 !== 32'hBB || ex_fwd_b !== 2'd2)
            $display("FAIL fwd_b_wb got %h/%h/%0d want 33/bb/2", ex_v1, ex_v2, ex_fwd_b); else passed++;
    endtask

    task automatic test_x0();
        quiet_fwd();
        load(0, 0, 4, 32'h11, 32'h44, 0, 0, 10'h010);
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFF;
        wb_reg_write = 1; wb_rd = 0; wb_result = 32'hEE;
        #1;
        total++; if (ex_v2 !== 32'h44 || ex_fwd_b !== 2'd0)
            $display("FAIL x0_b got %h/%0d want 44/0", ex_v2, ex_fwd_b); else passed++;
        total++; if (ex_v1 !== 32'h11 || ex_fwd_a !== 2'd0)
            $display("FAIL x0_a got %h/%0d want 11/0", ex_v1, ex_fwd_a); else passed++;
    endtask

    task automatic test_imm();
        quiet_fwd();
        load(1, 6, 5, 32'h1, 32'h66, 32'hFFFFFFFC, 1, 10'h020);
        exm_reg_write = 1; exm_rd = 6; exm_result = 32'h5555;
        #1;
        total++; if (ex_v2 !== 32'hFFFFFFFC || ex_fwd_b !== 2'd0)
            $display("FAIL imm got %h/%0d want fffffffc/0", ex_v2, ex_fwd_b); else passed++;
    endtask

    task automatic test_stall();
        quiet_fwd();
        load(7, 2, 9, 32'h11, 32'h22, 0, 0, 10'h123);
        stall = 1;
        id_rs1_addr = 1; id_rd_addr = 30; id_instructions = 10'h2aa;
        id_rs1_data = 32'hDEAD; id_valid = 0;
        wb_reg_write = 1; wb_rd = 7; wb_result = 32'h1234;
        tick();
        wb_reg_write = 0; wb_result = 0;
        tick();
        tick();
        total++; if (ex_rd !== 5'd9 || ex_instructions !== 10'h123 || ex_valid !== 1'b1)
            $display("FAIL stall_hold got rd%0d op%h v%0d want 9/123/1", ex_rd, ex_instructions, ex_valid); else passed++;
        total++; if (ex_v2 !== 32'h22) $display("FAIL stall_v2 got %h want 22", ex_v2); else passed++;
        stall = 0;
        #1;
        total++; if (ex_v1 !== 32'h1234 || ex_fwd_a !== 2'd0)
            $display("FAIL stall_refresh got %h/%0d want 1234/0", ex_v1, ex_fwd_a); else passed++;
    endtask

    task automatic test_flush_stall();
        quiet_fwd();
        load(3, 4, 6, 32'h3, 32'h4, 0, 0, 10'h155);
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0;
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_instructions !== 10'h0)
            $display("FAIL flush got v%0d rw%0d op%h want 0/0/0", ex_valid, ex_reg_write, ex_instructions); else passed++;
    endtask

    task automatic test_rst_mid_stall();
        quiet_fwd();
        load(3, 4, 6, 32'h3, 32'h4, 0, 0, 10'h155);
        stall = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; stall = 0;
        total++; if (ex_valid !== 0 || ex_reg_write !== 0 || ex_rd !== 0 || ex_instructions !== 0 ||
                     ex_v1 !== 0 || ex_v2 !== 0 || ex_fwd_a !== 0 || ex_fwd_b !== 0)
            $display("FAIL rst_stall got v%0d rw%0d rd%0d op%h v1%h v2%h", ex_valid, ex_reg_write,
                     ex_rd, ex_instructions, ex_v1, ex_v2); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            id_valid = $urandom; id_reg_write = $urandom; id_use_imm = $urandom;
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            id_rd_addr = 5'($urandom);
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_instructions = 10'($urandom);
            wb_reg_write = $urandom; wb_rd = 5'($urandom_range(0, 7));
            wb_result = $urandom;
            tick();
            exm_reg_write = $urandom; exm_rd = 5'($urandom_range(0, 7));
            exm_result = $urandom;
            wb_reg_write = $urandom; wb_rd = 5'($urandom_range(0, 7));
            wb_result = $urandom;
            #1;
            total++; if (ex_valid !== m_valid || ex_reg_write !== m_rw || ex_rd !== m_rd || ex_instructions !== m_op)
                $display("FAIL rnd_ctrl[%0d] got %0d/%0d/%0d/%h want %0d/%0d/%0d/%h", i, ex_valid,
                         ex_reg_write, ex_rd, ex_instructions, m_valid, m_rw, m_rd, m_op); else passed++;
            total++; if (ex_v1 !== e_v1() || ex_fwd_a !== e_fa())
                $display("FAIL rnd_a[%0d] got %h/%0d want %h/%0d", i, ex_v1, ex_fwd_a, e_v1(), e_fa()); else passed++;
            total++; if (ex_v2 !== e_v2() || ex_fwd_b !== e_fb())
                $display("FAIL rnd_b[%0d] got %h/%0d want %h/%0d", i, ex_v2, ex_fwd_b, e_v2(), e_fb()); else passed++;
        end
        rst = 0; flush = 0; stall = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward_priority();
        test_x0();
        test_imm();
        test_stall();
        test_flush_stall();
        test_rst_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
